b08_match_scheduler: RTL
========================

Name: b08_match_scheduler

Overview:
- Round-robin scheduler sharing one b08-style sequence-inclusion core (START / I[7:0] in, 4-bit O out, STATO-based busy) among NREQ requesters.
- Accepts a byte from the winning requester, launches the core, and tracks the core's busy window with a timeout.
- Returns the core's 4-bit result, tagged with the requester ID, as a one-cycle response.
- Sits between the requester fabric and the core; the core itself is a separate instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester ID; must satisfy 2**IDW >= NREQ.
- TIMEOUT, 32, max cycles allowed in the wait states before abort (>= 2).

Ports:
- CLOCK  in  1  rising-edge clock.
- RESET_N  in  1  asynchronous, active-low reset.
- REQ  in  NREQ  per-requester request level; held until granted.
- REQ_DATA  in  8*NREQ  requester k byte at bits [8k+7:8k].
- GNT  out  NREQ  one-hot, one-cycle grant pulse.
- RSP_VALID  out  1  one-cycle response strobe.
- RSP_ID  out  IDW  ID of the served requester.
- RSP_O  out  4  core result.
- RSP_ERR  out  1  timeout flag; qualified by RSP_VALID.
- CORE_START  out  1  one-cycle start pulse to the core.
- CORE_I  out  8  byte presented to the core.
- CORE_BUSY  in  1  core is not in its idle state.
- CORE_O  in  4  core output register.
- SCHED_BUSY  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any state): state=IDLE; GNT=0, RSP_VALID=0, RSP_ID=0, RSP_O=0, RSP_ERR=0, CORE_START=0, CORE_I=0, SCHED_BUSY=0; RR pointer=0; timer=0.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE:
  - If any REQ bit is high, the winner is the first set bit searching upward from the RR pointer, wrapping past NREQ-1 to 0.
  - At the clock edge: GNT[w]<=1, CORE_START<=1, CORE_I<=REQ_DATA[w], RSP_ID<=w, RR pointer<=(w+1) mod NREQ, timer<=0, next state LAUNCH.
  - If no REQ bit is high, the FSM stays in IDLE.
- LAUNCH (exactly 1 cycle): GNT and CORE_START are high in this cycle. Both clear at the next edge; next state WAIT_BUSY.
- WAIT_BUSY:
  - Timer increments every cycle.
  - CORE_BUSY=1 -> WAIT_DONE.
- WAIT_DONE:
  - Timer increments every cycle.
  - CORE_BUSY=0 -> capture RSP_O<=CORE_O, RSP_ERR<=0, RSP_VALID<=1; next state RESP.
- Timeout: if timer reaches TIMEOUT-1 in WAIT_BUSY or WAIT_DONE without completing, then RSP_O<=0, RSP_ERR<=1, RSP_VALID<=1; next state RESP. If completion and timeout occur in the same cycle, completion wins.
- RESP (1 cycle): RSP_VALID is high. At the next edge RSP_VALID clears and the state returns to IDLE. The new arbitration evaluates in that IDLE cycle.
- RSP_ID, RSP_O and RSP_ERR hold their values until the next response.
- CORE_I is stable from LAUNCH through the end of WAIT_DONE.
- Requester obligations: REQ[k] must stay high until GNT[k]. REQ_DATA[k] must be stable while REQ[k] is high.
- Request dropped before grant: silently ignored; no response is generated.
- REQ bits for requesters other than the one being served are ignored until IDLE. No queueing beyond the REQ levels.
- REQ[w] still high after its grant: treated as a new request at the next IDLE.
- Minimum service time: IDLE -> LAUNCH -> WAIT_BUSY -> WAIT_DONE -> RESP = 5 cycles per transaction, plus the core busy time.

Test Plan:
- Single request: REQ=4'b0100, data 8'hA5; core model holds busy 10 cycles, then O=4'h9.
  -> GNT=4'b0100 with CORE_START in the same cycle; CORE_I=8'hA5.
  -> RSP_VALID one cycle with RSP_ID=2, RSP_O=9, RSP_ERR=0.
- Fairness: REQ=4'b1111 held continuously (re-raised after each grant).
  -> Grant order 0,1,2,3,0.
  -> Each GNT is one-hot and one cycle long; no GNT while SCHED_BUSY=1 except in LAUNCH.
- Wrap: pointer at 3 with REQ=4'b1001.
  -> Requester 3 granted first, then requester 0.
- Timeout: core never raises CORE_BUSY.
  -> RSP_VALID with RSP_ERR=1, RSP_O=0 after TIMEOUT wait cycles.
  -> FSM returns to IDLE and serves the next request normally.
- Reset mid-operation: assert RESET_N=0 in WAIT_DONE.
  -> All outputs 0 immediately, without waiting for a clock edge.
  -> After release, REQ=4'b0010 is granted to requester 1 (pointer restarted at 0).
- Simultaneous completion and timeout: CORE_BUSY falls in the same cycle the timer hits TIMEOUT-1.
  -> RSP_ERR=0 and RSP_O=CORE_O.

Source files
------------

// File: rtl/b08_match_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : b08_match_scheduler
//  Brief    : Round-robin scheduler sharing one b08 sequence-inclusion core
//             among NREQ requesters, with a timeout on the core busy window.
//  Revision : 1.0
// ============================================================================
module b08_match_scheduler #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 32
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic [NREQ-1:0]   REQ,
    input  logic [8*NREQ-1:0] REQ_DATA,
    output logic [NREQ-1:0]   GNT,
    output logic              RSP_VALID,
    output logic [IDW-1:0]    RSP_ID,
    output logic [3:0]        RSP_O,
    output logic              RSP_ERR,
    output logic              CORE_START,
    output logic [7:0]        CORE_I,
    input  logic              CORE_BUSY,
    input  logic [3:0]        CORE_O,
    output logic              SCHED_BUSY
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_LAUNCH    = 3'd1;
    localparam logic [2:0] c_WAIT_BUSY = 3'd2;
    localparam logic [2:0] c_WAIT_DONE = 3'd3;
    localparam logic [2:0] c_RESP      = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [3:0]      rsp_o_q, rsp_o_d;
    logic            rsp_err_q, rsp_err_d;
    logic            core_start_q, core_start_d;
    logic [7:0]      core_i_q, core_i_d;
    logic            sched_busy_q, sched_busy_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [TW-1:0]   timer_q, timer_d;

    logic            w_found;
    logic [IDW-1:0]  w_win;
    logic            w_timeout;

    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    // Scanning downward in offset lets the nearest request above the pointer win.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (REQ[rr_index(ptr_q, i)]) begin
                w_found = 1'b1;
                w_win   = rr_index(ptr_q, i);
            end
        end
    end

    assign w_timeout = (timer_q >= TW'(TIMEOUT - 1));

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= c_IDLE;
            gnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_o_q      <= '0;
            rsp_err_q    <= 1'b0;
            core_start_q <= 1'b0;
            core_i_q     <= '0;
            sched_busy_q <= 1'b0;
            ptr_q        <= '0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_o_q      <= rsp_o_d;
            rsp_err_q    <= rsp_err_d;
            core_start_q <= core_start_d;
            core_i_q     <= core_i_d;
            sched_busy_q <= sched_busy_d;
            ptr_q        <= ptr_d;
            timer_q      <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:      if (w_found) state_d = c_LAUNCH;
            c_LAUNCH:    state_d = c_WAIT_BUSY;
            c_WAIT_BUSY: begin
                if (CORE_BUSY)      state_d = c_WAIT_DONE;
                else if (w_timeout) state_d = c_RESP;
            end
            c_WAIT_DONE: if (!CORE_BUSY || w_timeout) state_d = c_RESP;
            c_RESP:      state_d = c_IDLE;
            default:     state_d = c_IDLE;
        endcase
    end

    always_comb begin
        gnt_d        = '0;
        core_start_d = 1'b0;
        rsp_valid_d  = 1'b0;
        core_i_d     = core_i_q;
        rsp_id_d     = rsp_id_q;
        rsp_o_d      = rsp_o_q;
        rsp_err_d    = rsp_err_q;
        ptr_d        = ptr_q;
        timer_d      = timer_q;
        sched_busy_d = (state_d != c_IDLE);
        case (state_q)
            c_IDLE: begin
                if (w_found) begin
                    gnt_d        = NREQ'(1) << w_win;
                    core_start_d = 1'b1;
                    core_i_d     = REQ_DATA[8*w_win +: 8];
                    rsp_id_d     = w_win;
                    ptr_d        = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + IDW'(1);
                    timer_d      = '0;
                end
            end
            c_WAIT_BUSY: begin
                if (CORE_BUSY) begin
                    timer_d = timer_q + TW'(1);
                end else if (w_timeout) begin
                    rsp_o_d     = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            // Completion is tested before the timeout so a same-cycle tie reports success.
            c_WAIT_DONE: begin
                if (!CORE_BUSY) begin
                    rsp_o_d     = CORE_O;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                end else if (w_timeout) begin
                    rsp_o_d     = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: ;
        endcase
    end

    assign GNT        = gnt_q;
    assign RSP_VALID  = rsp_valid_q;
    assign RSP_ID     = rsp_id_q;
    assign RSP_O      = rsp_o_q;
    assign RSP_ERR    = rsp_err_q;
    assign CORE_START = core_start_q;
    assign CORE_I     = core_i_q;
    assign SCHED_BUSY = sched_busy_q;

endmodule
`default_nettype wire
